// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vec_pkg
// Description : Shared constants and types for the vector memory sequencer.
//               The vector geometry lives here so the sequencer, its lane
//               counter and any client agree on lane count and word width.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int LANES  = 8;
    localparam int WIDTH  = 32;
    localparam int LANE_W = $clog2(LANES);
    localparam int VEC_W  = LANES * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vseq_state_t;

endpackage
`default_nettype wire

// File: rtl/vec_lane_counter.sv
`default_nettype none
// ============================================================================
// Module      : vec_lane_counter
// Description : Lane index for a serialised vector access. Clear has
//               priority over enable; 'last' flags the final lane so the
//               sequencer can leave ACCESS on that lane's acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_lane_counter
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [LANE_W-1:0] lane,
    output logic              last
);

    logic [LANE_W-1:0] cnt_q;
    logic [LANE_W-1:0] cnt_d;

    // Next count: clear to lane 0, otherwise step on each completed transfer
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + LANE_W'(1);
        end
    end

    // Counter register, forced to lane 0 by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lane = cnt_q;
    assign last = (cnt_q == LANE_W'(LANES - 1));

endmodule
`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_mem_sequencer
// Description : M-stage sequencer that serialises a vector load/store into
//               one word transfer per lane on a single 32-bit memory port,
//               stalls the pipeline for the duration and gathers load words
//               into a full vector for the register write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_sequencer
    import vec_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               vmemM,
    input  logic               memwriteM,
    input  logic [31:0]        baseaddrM,
    input  logic [VEC_W-1:0]   vwritedataM,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               stallM,
    output logic               vdoneM,
    output logic [VEC_W-1:0]   vreaddataM
);

    vseq_state_t        state_q;
    vseq_state_t        state_d;
    logic [31:0]        base_q;
    logic [31:0]        base_d;
    logic               we_q;
    logic               we_d;
    logic [VEC_W-1:0]   wdata_q;
    logic [VEC_W-1:0]   wdata_d;
    logic [VEC_W-1:0]   vread_q;
    logic [VEC_W-1:0]   vread_d;

    logic [LANE_W-1:0]  lane;
    logic               lane_last;
    logic               lane_clr;
    logic               lane_en;
    logic               start;
    logic               xfer_done;

    // Byte offset within the word is dropped: transfers are word aligned.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^baseaddrM[1:0];

    assign start     = (state_q == IDLE) && vmemM;
    assign xfer_done = (state_q == ACCESS) && mem_ack;
    assign lane_clr  = start;
    assign lane_en   = xfer_done;

    vec_lane_counter u_lane_counter (
        .clk   (clk),
        .rst_n (reset),
        .clr   (lane_clr),
        .en    (lane_en),
        .lane  (lane),
        .last  (lane_last)
    );

    // State and latched operand registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            vread_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            vread_q <= vread_d;
        end
    end

    // Next state: one ACCESS pass per instruction, DONE lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vmemM)                  state_d = ACCESS;
            ACCESS:  if (mem_ack && lane_last)   state_d = DONE;
            DONE:                                state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Operand capture at instruction start; M-stage inputs are ignored afterwards
    always_comb begin
        base_d  = base_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        if (start) begin
            base_d  = {baseaddrM[31:2], 2'b00};
            we_d    = memwriteM;
            wdata_d = vwritedataM;
        end
    end

    // Gather each acknowledged load word into its lane; stores leave the vector alone
    always_comb begin
        vread_d = vread_q;
        if (xfer_done && !we_q) begin
            vread_d[int'(lane) * WIDTH +: WIDTH] = mem_rdata;
        end
    end

    // Moore outputs, except the IDLE stall which must react to vmemM in the same cycle
    always_comb begin
        stallM    = 1'b0;
        vdoneM    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                stallM = vmemM & reset;
            end
            ACCESS: begin
                stallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_q + (32'(lane) << 2);
                mem_wdata = wdata_q[int'(lane) * WIDTH +: WIDTH];
            end
            DONE: begin
                vdoneM = 1'b1;
            end
            default: begin
                stallM = 1'b0;
            end
        endcase
    end

    assign vreaddataM = vread_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_mem_sequencer
// Description : Self-checking bench for vector_mem_sequencer. A responder
//               acknowledges each lane after a chosen number of wait cycles
//               and a vector-level model tracks the gathered load data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_mem_sequencer;
    import vec_pkg::*;

    logic               clk;
    logic               reset;
    logic               vmemM;
    logic               memwriteM;
    logic [31:0]        baseaddrM;
    logic [VEC_W-1:0]   vwritedataM;
    logic               mem_ack;
    logic [WIDTH-1:0]   mem_rdata;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic               stallM;
    logic               vdoneM;
    logic [VEC_W-1:0]   vreaddataM;

    int                 n_checks;
    int                 n_fail;
    logic [VEC_W-1:0]   mdl_vread;

    vector_mem_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .vmemM       (vmemM),
        .memwriteM   (memwriteM),
        .baseaddrM   (baseaddrM),
        .vwritedataM (vwritedataM),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .stallM      (stallM),
        .vdoneM      (vdoneM),
        .vreaddataM  (vreaddataM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    // One full vector op. Entered at a negedge with the DUT in IDLE, leaves at the
    // negedge of the IDLE cycle after DONE. 'hold' keeps vmemM high through DONE.
    task automatic run_op(input string nm, input logic we, input logic [31:0] base,
                          input logic [VEC_W-1:0] wd, input logic [VEC_W-1:0] rdv,
                          input int wmin, input int wmax, input bit hold);
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        int          w;
        int          stalls;
        int          exp_stalls;
        vmemM = 1'b1; memwriteM = we; baseaddrM = base; vwritedataM = wd; mem_ack = 1'b0;
        mem_rdata = WIDTH'($urandom);
        #1;
        n_checks++; if (stallM !== 1'b1) begin n_fail++; $display("FAIL %s idle_stall: got %b expected 1", nm, stallM); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s idle_req: got %b expected 0", nm, mem_req); end
        stalls = (stallM === 1'b1) ? 1 : 0;
        exp_stalls = 1;
        @(posedge clk); @(negedge clk);
        // Inputs change freely during the access; the latched copies must be used
        vmemM = 1'($urandom); memwriteM = ~we; baseaddrM = $urandom; vwritedataM = rand_vec();
        for (int i = 0; i < LANES; i++) begin
            w = $urandom_range(wmax, wmin);
            exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_wd   = wd[i*WIDTH +: WIDTH];
            for (int c = 0; c <= w; c++) begin
                mem_ack   = (c == w);
                mem_rdata = (c == w) ? rdv[i*WIDTH +: WIDTH] : WIDTH'($urandom);
                #1;
                n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL %s req lane%0d: got %b expected 1", nm, i, mem_req); end
                n_checks++; if (mem_we !== we) begin n_fail++; $display("FAIL %s we lane%0d: got %b expected %b", nm, i, mem_we, we); end
                n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL %s addr lane%0d: got %h expected %h", nm, i, mem_addr, exp_addr); end
                n_checks++; if (mem_wdata !== exp_wd) begin n_fail++; $display("FAIL %s wdata lane%0d: got %h expected %h", nm, i, mem_wdata, exp_wd); end
                n_checks++; if (vdoneM !== 1'b0) begin n_fail++; $display("FAIL %s early_done lane%0d: got %b expected 0", nm, i, vdoneM); end
                if (stallM === 1'b1) stalls++;
                exp_stalls++;
                @(posedge clk); @(negedge clk);
            end
            if (!we) mdl_vread[i*WIDTH +: WIDTH] = rdv[i*WIDTH +: WIDTH];
        end
        // DONE cycle: vmemM here is still the finished instruction and must be ignored
        mem_ack = 1'b0; vmemM = hold; memwriteM = 1'($urandom); baseaddrM = $urandom;
        #1;
        n_checks++; if (vdoneM !== 1'b1) begin n_fail++; $display("FAIL %s done_pulse: got %b expected 1", nm, vdoneM); end
        n_checks++; if (stallM !== 1'b0) begin n_fail++; $display("FAIL %s done_stall: got %b expected 0", nm, stallM); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL %s done_req: got %b expected 0", nm, mem_req); end
        n_checks++; if (stalls !== exp_stalls) begin n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stalls, exp_stalls); end
        @(posedge clk); @(negedge clk);
        #1;
        n_checks++; if (vdoneM !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got %b expected 0", nm, vdoneM); end
        n_checks++; if (stallM !== hold) begin n_fail++; $display("FAIL %s next_idle_stall: got %b expected %b", nm, stallM, hold); end
        n_checks++; if (vreaddataM !== mdl_vread) begin n_fail++; $display("FAIL %s vreaddata: got %h expected %h", nm, vreaddataM, mdl_vread); end
    endtask

    task automatic test_reset();
        reset = 1'b0; vmemM = 1'b1; memwriteM = 1'b1; baseaddrM = $urandom;
        vwritedataM = rand_vec(); mem_ack = 1'b1; mem_rdata = WIDTH'($urandom);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if ({mem_req, mem_we, stallM, vdoneM} !== 4'b0) begin n_fail++; $display("FAIL reset ctrl: got %b expected 0000", {mem_req, mem_we, stallM, vdoneM}); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== '0) begin n_fail++; $display("FAIL reset addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        n_checks++; if (vreaddataM !== '0) begin n_fail++; $display("FAIL reset vreaddata: got %h expected 0", vreaddataM); end
        mdl_vread = '0;
        vmemM = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Scalar ops and stray acknowledges in IDLE must not disturb anything
    task automatic test_idle_quiet();
        for (int k = 0; k < 6; k++) begin
            vmemM = 1'b0; memwriteM = 1'($urandom); baseaddrM = $urandom;
            mem_ack = 1'($urandom); mem_rdata = WIDTH'($urandom);
            #1;
            n_checks++; if ({stallM, mem_req, vdoneM} !== 3'b0) begin n_fail++; $display("FAIL idle_quiet ctrl%0d: got %b expected 000", k, {stallM, mem_req, vdoneM}); end
            n_checks++; if (vreaddataM !== mdl_vread) begin n_fail++; $display("FAIL idle_quiet vread%0d: got %h expected %h", k, vreaddataM, mdl_vread); end
            @(posedge clk); @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_load_zero_wait();
        logic [VEC_W-1:0] rdv;
        for (int i = 0; i < LANES; i++) rdv[i*WIDTH +: WIDTH] = WIDTH'(32'hA0 + i);
        run_op("load0", 1'b0, 32'h0000_0100, rand_vec(), rdv, 0, 0, 1'b0);
    endtask

    task automatic test_store_misaligned();
        logic [VEC_W-1:0] wd;
        for (int i = 0; i < LANES; i++) wd[i*WIDTH +: WIDTH] = WIDTH'(32'h1111_1111 * i);
        run_op("store", 1'b1, 32'h0000_0203, wd, rand_vec(), 0, 0, 1'b0);
    endtask

    task automatic test_wait_states();
        run_op("wait2", 1'b0, 32'h0000_4000, rand_vec(), rand_vec(), 2, 2, 1'b0);
    endtask

    task automatic test_wrap();
        run_op("wrap", 1'b0, 32'hFFFF_FFF8, rand_vec(), rand_vec(), 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_load", 1'b0, 32'h0000_0800, rand_vec(), rand_vec(), 0, 1, 1'b1);
        run_op("b2b_store", 1'b1, 32'h0000_0900, rand_vec(), rand_vec(), 0, 1, 1'b0);
    endtask

    // Reset pulsed while lane 3 is on the bus, then a fresh op must start at lane 0
    task automatic test_reset_abort();
        vmemM = 1'b1; memwriteM = 1'b1; baseaddrM = 32'h0000_0C00; vwritedataM = rand_vec(); mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        vmemM = 1'b0; mem_ack = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        mem_ack = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 32'h0000_0C0C) begin n_fail++; $display("FAIL abort lane3_addr: got %h expected 00000c0c", mem_addr); end
        reset = 1'b0;
        #1;
        n_checks++; if ({mem_req, mem_we, stallM, vdoneM} !== 4'b0) begin n_fail++; $display("FAIL abort ctrl: got %b expected 0000", {mem_req, mem_we, stallM, vdoneM}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL abort addr: got %h expected 0", mem_addr); end
        n_checks++; if (vreaddataM !== '0) begin n_fail++; $display("FAIL abort vreaddata: got %h expected 0", vreaddataM); end
        mdl_vread = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("after_abort", 1'b0, 32'h0000_0C40, rand_vec(), rand_vec(), 0, 2, 1'b0);
    endtask

    task automatic test_random();
        int n;
        n = 16;
        for (int k = 0; k < n; k++) begin
            run_op("rand", 1'($urandom), $urandom, rand_vec(), rand_vec(), 0, 3,
                   (k != n - 1) ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; mdl_vread = '0;
        test_reset();
        test_idle_quiet();
        test_load_zero_wait();
        test_idle_quiet();
        test_store_misaligned();
        test_wait_states();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_idle_quiet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
